mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single data-memory/IO bus between two requesters: the multi-cycle MIPS core (CPU port) and a debug/program-loader master (DBG port).
- Sits directly in front of the memory decoder and drives its writeEN/addr/writeData, taking readData back.
- Sequences each transaction as one request/ack handshake with round-robin arbitration, so neither master starves.

Parameters:
- ACCESS_CYCLES, 1, cycles the bus is held per access before readData is sampled. Legal range is 1..15; 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cpuReq  input  1  CPU access request, level; held until cpuAck
- cpuWe  input  1  CPU write (1) / read (0)
- cpuAddr  input  32  CPU byte address
- cpuWData  input  32  CPU write data
- cpuRData  output  32  CPU read data, registered
- cpuAck  output  1  one-cycle completion pulse to CPU
- dbgReq  input  1  DBG access request, level; held until dbgAck
- dbgWe  input  1  DBG write (1) / read (0)
- dbgAddr  input  32  DBG byte address
- dbgWData  input  32  DBG write data
- dbgRData  output  32  DBG read data, registered
- dbgAck  output  1  one-cycle completion pulse to DBG
- memWriteEN  output  1  to decoder writeEN
- memAddr  output  32  to decoder addr
- memWriteData  output  32  to decoder writeData
- memReadData  input  32  from decoder readData
- busOwner  output  2  00 none, 01 CPU, 10 DBG

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, busOwner 00, acks 0, memWriteEN 0, memAddr 0, memWriteData 0, cpuRData 0, dbgRData 0, lastOwner = DBG (so the CPU wins the first tie), counter 0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, arbitration at the clock edge:
  - One requester: grant it.
  - Both: grant the one not equal to lastOwner.
  - On grant: latch the winner's we/addr/wdata into memAddr/memWriteData/weReg, set busOwner, counter = ACCESS_CYCLES-1, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - memAddr/memWriteData are held from the latched registers.
  - memWriteEN = weReg only in the first ACCESS cycle; exactly one write pulse per write transaction.
  - Counter decrements each cycle.
  - At the edge where counter==0: if a read, capture memReadData into the owner's RData register (the other RData register is unchanged). Then go to DONE.
- DONE:
  - Owner's ack = 1 for this single cycle.
  - lastOwner updated to the owner.
  - Next edge: busOwner 00, go to IDLE.
- Latency: req sampled at edge 0, ack high in cycle ACCESS_CYCLES+1 after that edge; the default is ack 2 cycles after grant.
  - Back-to-back: the other requester is granted at the IDLE edge following DONE, so the bus is idle one cycle between transactions.
- Requester rules:
  - Drops req at the edge ending its ack cycle, or raises a new req later.
  - A req still high in IDLE is treated as a new transaction.
- RData: valid from the ack cycle; held until that requester's next read completes. Writes do not alter RData.
- Boundary conditions:
  - Req dropped mid-ACCESS: transaction completes and ack still pulses.
  - Addr/data changing mid-ACCESS: ignored, because they are latched.
  - Simultaneous first requests after reset: CPU granted first, then DBG.
  - Continuous dual requests: grants strictly alternate CPU, DBG, CPU, ...
  - Reset mid-ACCESS or mid-DONE: outputs go to reset values immediately; no ack; a write whose pulse cycle has not reached its clock edge is not issued.
- memWriteEN never asserts in IDLE or DONE.

Test Plan:
- Single CPU read: memReadData=32'h1234_5678 at addr 32'h0000_0010, cpuReq=1 cpuWe=0 -> memAddr=0x10 next cycle; cpuAck pulses 2 cycles after grant; cpuRData=0x12345678; memWriteEN stays 0.
- Single DBG write: addr 32'h0000_0080, data 32'hDEAD_BEEF -> memWriteEN high exactly one cycle with memAddr=0x80 and memWriteData=0xDEADBEEF; dbgAck pulses one cycle; dbgRData unchanged.
- Both requesting continuously from reset, 4 transactions -> busOwner sequence 01,10,01,10; each ack appears only on the owner side; one IDLE cycle between transactions.
- ACCESS_CYCLES=3: memReadData changes 0xAAAA->0xBBBB during ACCESS cycle 2 and is 0xCCCC in the final cycle -> captured RData=0xCCCC; ack 4 cycles after grant.
- Reset asserted in the first ACCESS cycle of a CPU write -> memWriteEN, busOwner and cpuAck go to 0 immediately; no ack; after release, a pending dbgReq is granted first.
- cpuAddr changed and cpuReq dropped mid-ACCESS -> memAddr keeps the original address; cpuAck still pulses once.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU/DBG requesters, the bus arbiter and the memory decoder.
// The slave modport is the arbiter's view; the master modport is the requester/decoder side.
interface mem_bus_arbiter_if;
    logic        cpuReq;
    logic        cpuWe;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWData;
    logic [31:0] cpuRData;
    logic        cpuAck;
    logic        dbgReq;
    logic        dbgWe;
    logic [31:0] dbgAddr;
    logic [31:0] dbgWData;
    logic [31:0] dbgRData;
    logic        dbgAck;
    logic        memWriteEN;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic [1:0]  busOwner;

    modport slave (
        input  cpuReq, cpuWe, cpuAddr, cpuWData,
        output cpuRData, cpuAck,
        input  dbgReq, dbgWe, dbgAddr, dbgWData,
        output dbgRData, dbgAck,
        output memWriteEN, memAddr, memWriteData,
        input  memReadData,
        output busOwner
    );

    modport master (
        output cpuReq, cpuWe, cpuAddr, cpuWData,
        input  cpuRData, cpuAck,
        output dbgReq, dbgWe, dbgAddr, dbgWData,
        input  dbgRData, dbgAck,
        input  memWriteEN, memAddr, memWriteData,
        output memReadData,
        input  busOwner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory/IO bus between the MIPS core (CPU) and a
// debug/program-loader master (DBG); one request/ack handshake per transaction.
module mem_bus_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [1:0]  OWN_NONE = 2'b00;
    localparam logic [1:0]  OWN_CPU  = 2'b01;
    localparam logic [1:0]  OWN_DBG  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_owner;
    logic             r_last_dbg;
    logic             r_we;
    logic             r_wen;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_cpu_rdata;
    logic [31:0]      r_dbg_rdata;
    logic             r_cpu_ack;
    logic             r_dbg_ack;

    logic w_grant_cpu;
    logic w_grant_dbg;

    // On a tie the requester that did not own the bus last time wins
    assign w_grant_cpu = bus.cpuReq & (~bus.dbgReq | r_last_dbg);
    assign w_grant_dbg = bus.dbgReq & ~w_grant_cpu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner     <= OWN_NONE;
            r_last_dbg  <= 1'b1;
            r_we        <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dbg_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_cpu || w_grant_dbg) begin
                        r_we    <= w_grant_cpu ? bus.cpuWe    : bus.dbgWe;
                        r_wen   <= w_grant_cpu ? bus.cpuWe    : bus.dbgWe;
                        r_addr  <= w_grant_cpu ? bus.cpuAddr  : bus.dbgAddr;
                        r_wdata <= w_grant_cpu ? bus.cpuWData : bus.dbgWData;
                        r_owner <= w_grant_cpu ? OWN_CPU      : OWN_DBG;
                        r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Write strobe lives only in the first access cycle
                    r_wen <= 1'b0;
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner == OWN_CPU) r_cpu_rdata <= bus.memReadData;
                            else                    r_dbg_rdata <= bus.memReadData;
                        end
                        r_cpu_ack <= (r_owner == OWN_CPU);
                        r_dbg_ack <= (r_owner == OWN_DBG);
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_cpu_ack  <= 1'b0;
                    r_dbg_ack  <= 1'b0;
                    r_last_dbg <= (r_owner == OWN_DBG);
                    r_owner    <= OWN_NONE;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.memWriteEN   = r_wen;
    assign bus.memAddr      = r_addr;
    assign bus.memWriteData = r_wdata;
    assign bus.busOwner     = r_owner;
    assign bus.cpuRData     = r_cpu_rdata;
    assign bus.dbgRData     = r_dbg_rdata;
    assign bus.cpuAck       = r_cpu_ack;
    assign bus.dbgAck       = r_dbg_ack;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: one instance with ACCESS_CYCLES=1
// and one with ACCESS_CYCLES=3, both on a shared clock and reset.
module tb_mem_bus_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_bus_arbiter_if bus1 ();
    mem_bus_arbiter_if bus3 ();

    mem_bus_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_bus_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus1.cpuReq = 1'b0; bus1.cpuWe = 1'b0; bus1.cpuAddr = '0; bus1.cpuWData = '0;
        bus1.dbgReq = 1'b0; bus1.dbgWe = 1'b0; bus1.dbgAddr = '0; bus1.dbgWData = '0;
        bus1.memReadData = '0;
        bus3.cpuReq = 1'b0; bus3.cpuWe = 1'b0; bus3.cpuAddr = '0; bus3.cpuWData = '0;
        bus3.dbgReq = 1'b0; bus3.dbgWe = 1'b0; bus3.dbgAddr = '0; bus3.dbgWData = '0;
        bus3.memReadData = '0;
        tick();
        tick();
        check("rst_owner",    32'(bus1.busOwner),   32'h0);
        check("rst_wen",      32'(bus1.memWriteEN), 32'h0);
        check("rst_addr",     bus1.memAddr,         32'h0);
        check("rst_acks",     32'({bus1.cpuAck, bus1.dbgAck}), 32'h0);
        check("rst_cpu_rd",   bus1.cpuRData,        32'h0);
        reset = 1'b0;
        tick();
        check("idle_owner",   32'(bus1.busOwner),   32'h0);

        // Single CPU read
        bus1.memReadData = 32'h1234_5678;
        bus1.cpuReq = 1'b1; bus1.cpuWe = 1'b0; bus1.cpuAddr = 32'h0000_0010;
        tick();
        check("rd_addr",      bus1.memAddr,         32'h0000_0010);
        check("rd_owner",     32'(bus1.busOwner),   32'h1);
        check("rd_wen_acc",   32'(bus1.memWriteEN), 32'h0);
        check("rd_ack_early", 32'(bus1.cpuAck),     32'h0);
        tick();
        check("rd_ack",       32'(bus1.cpuAck),     32'h1);
        check("rd_data",      bus1.cpuRData,        32'h1234_5678);
        check("rd_wen_done",  32'(bus1.memWriteEN), 32'h0);
        bus1.cpuReq = 1'b0;
        tick();
        check("rd_ack_off",   32'(bus1.cpuAck),     32'h0);
        check("rd_idle",      32'(bus1.busOwner),   32'h0);

        // Single DBG write
        bus1.dbgReq = 1'b1; bus1.dbgWe = 1'b1;
        bus1.dbgAddr = 32'h0000_0080; bus1.dbgWData = 32'hDEAD_BEEF;
        tick();
        check("wr_wen",       32'(bus1.memWriteEN), 32'h1);
        check("wr_addr",      bus1.memAddr,         32'h0000_0080);
        check("wr_data",      bus1.memWriteData,    32'hDEAD_BEEF);
        check("wr_owner",     32'(bus1.busOwner),   32'h2);
        tick();
        check("wr_wen_off",   32'(bus1.memWriteEN), 32'h0);
        check("wr_ack",       32'(bus1.dbgAck),     32'h1);
        check("wr_cpu_ack",   32'(bus1.cpuAck),     32'h0);
        check("wr_rdata",     bus1.dbgRData,        32'h0);
        bus1.dbgReq = 1'b0;
        tick();
        check("wr_ack_off",   32'(bus1.dbgAck),     32'h0);

        // Continuous dual requests: grants alternate CPU, DBG, CPU, DBG
        bus1.cpuReq = 1'b1; bus1.cpuWe = 1'b0; bus1.cpuAddr = 32'h0000_0100;
        bus1.dbgReq = 1'b1; bus1.dbgWe = 1'b0; bus1.dbgAddr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_own;
            exp_own = (k % 2 == 0) ? 2'b01 : 2'b10;
            bus1.memReadData = 32'h0000_1000 + 32'(k);
            tick();
            check($sformatf("rr_owner%0d", k), 32'(bus1.busOwner), 32'(exp_own));
            tick();
            check($sformatf("rr_cack%0d", k), 32'(bus1.cpuAck), 32'(exp_own == 2'b01));
            check($sformatf("rr_dack%0d", k), 32'(bus1.dbgAck), 32'(exp_own == 2'b10));
            if (exp_own == 2'b01) check($sformatf("rr_crd%0d", k), bus1.cpuRData, 32'h0000_1000 + 32'(k));
            else                  check($sformatf("rr_drd%0d", k), bus1.dbgRData, 32'h0000_1000 + 32'(k));
            tick();
            check($sformatf("rr_idle%0d", k), 32'(bus1.busOwner), 32'h0);
        end
        bus1.cpuReq = 1'b0; bus1.dbgReq = 1'b0;

        // ACCESS_CYCLES=3: only the value present at the final access edge is captured
        bus3.memReadData = 32'h0000_AAAA;
        bus3.cpuReq = 1'b1; bus3.cpuWe = 1'b0; bus3.cpuAddr = 32'h0000_0020;
        tick();
        check("a3_owner",     32'(bus3.busOwner),   32'h1);
        bus3.memReadData = 32'h0000_BBBB;
        tick();
        check("a3_ack_c2",    32'(bus3.cpuAck),     32'h0);
        bus3.memReadData = 32'h0000_CCCC;
        tick();
        check("a3_ack_c3",    32'(bus3.cpuAck),     32'h0);
        tick();
        check("a3_ack",       32'(bus3.cpuAck),     32'h1);
        check("a3_data",      bus3.cpuRData,        32'h0000_CCCC);
        bus3.cpuReq = 1'b0;
        tick();
        check("a3_ack_off",   32'(bus3.cpuAck),     32'h0);

        // Address change and request drop mid-access are ignored
        bus3.cpuReq = 1'b1; bus3.cpuWe = 1'b1;
        bus3.cpuAddr = 32'h0000_0040; bus3.cpuWData = 32'h0000_0055;
        tick();
        check("md_wen",       32'(bus3.memWriteEN), 32'h1);
        check("md_addr0",     bus3.memAddr,         32'h0000_0040);
        bus3.cpuAddr = 32'h0000_0044; bus3.cpuReq = 1'b0;
        tick();
        check("md_addr1",     bus3.memAddr,         32'h0000_0040);
        check("md_wen_off",   32'(bus3.memWriteEN), 32'h0);
        tick();
        check("md_addr2",     bus3.memAddr,         32'h0000_0040);
        check("md_ack_early", 32'(bus3.cpuAck),     32'h0);
        tick();
        check("md_ack",       32'(bus3.cpuAck),     32'h1);
        check("md_rdata",     bus3.cpuRData,        32'h0000_CCCC);
        tick();
        check("md_ack_off",   32'(bus3.cpuAck),     32'h0);
        tick();
        check("md_no_regrant", 32'(bus3.busOwner),  32'h0);

        // Reset during the first access cycle of a CPU write
        bus1.cpuReq = 1'b1; bus1.cpuWe = 1'b1;
        bus1.cpuAddr = 32'h0000_0300; bus1.cpuWData = 32'h0BAD_F00D;
        tick();
        check("rs_wen_pre",   32'(bus1.memWriteEN), 32'h1);
        reset = 1'b1;
        bus1.cpuReq = 1'b0;
        bus1.dbgReq = 1'b1; bus1.dbgWe = 1'b0; bus1.dbgAddr = 32'h0000_0400;
        bus1.memReadData = 32'h7777_0000;
        #1;
        check("rs_wen",       32'(bus1.memWriteEN), 32'h0);
        check("rs_owner",     32'(bus1.busOwner),   32'h0);
        check("rs_cack",      32'(bus1.cpuAck),     32'h0);
        check("rs_addr",      bus1.memAddr,         32'h0);
        tick();
        check("rs_hold_wen",  32'(bus1.memWriteEN), 32'h0);
        reset = 1'b0;
        tick();
        check("rs_dbg_first", 32'(bus1.busOwner),   32'h2);
        check("rs_dbg_addr",  bus1.memAddr,         32'h0000_0400);
        tick();
        check("rs_dbg_ack",   32'(bus1.dbgAck),     32'h1);
        check("rs_no_cack",   32'(bus1.cpuAck),     32'h0);
        check("rs_dbg_rd",    bus1.dbgRData,        32'h7777_0000);
        bus1.dbgReq = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
